// File: rtl/calc_port_scheduler_if.sv
// Request/response channel between calc_port_scheduler and the shared calc ALU.
// The master side issues tagged requests; the slave side returns tagged results.
interface calc_port_scheduler_if #(
    parameter int DW   = 32,
    parameter int TAGW = 2
);
    logic            alu_req_valid;
    logic            alu_req_ready;
    logic [3:0]      alu_cmd;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [TAGW-1:0] alu_req_tag;
    logic            alu_resp_valid;
    logic [1:0]      alu_resp;
    logic [DW-1:0]   alu_result;
    logic [TAGW-1:0] alu_resp_tag;

    modport master (
        output alu_req_valid, alu_cmd, alu_op1, alu_op2, alu_req_tag,
        input  alu_req_ready, alu_resp_valid, alu_resp, alu_result, alu_resp_tag
    );

    modport slave (
        input  alu_req_valid, alu_cmd, alu_op1, alu_op2, alu_req_tag,
        output alu_req_ready, alu_resp_valid, alu_resp, alu_result, alu_resp_tag
    );
endinterface

// File: rtl/calc_port_scheduler.sv
// Shares one calc ALU between NPORTS two-cycle requester ports with round-robin issue.
// Optional per-port response watchdog: define CALC_SCHED_TIMEOUT_EN.
module calc_port_scheduler #(
    parameter int NPORTS  = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int TAGW    = 2
) (
    input  logic                   c_clk,
    input  logic                   reset,
    input  logic [4*NPORTS-1:0]    req_cmd_in,
    input  logic [DW*NPORTS-1:0]   req_data_in,
    output logic [2*NPORTS-1:0]    out_resp,
    output logic [DW*NPORTS-1:0]   out_data,
    calc_port_scheduler_if.master  alu
);
    if (NPORTS < 2 || NPORTS > 4 || (2**TAGW) < NPORTS || TIMEOUT < 1) begin : g_param_check
        $error("calc_port_scheduler: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND, S_ISSUED} port_state_t;

    port_state_t     state [NPORTS];
    logic [3:0]      cmd_q [NPORTS];
    logic [DW-1:0]   op1_q [NPORTS];
    logic [DW-1:0]   op2_q [NPORTS];
    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] scan_idx;
    logic [TAGW-1:0] gnt_idx;
    logic            gnt_found;

`ifdef CALC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt [NPORTS];
`endif

    function automatic logic is_alu_cmd(input logic [3:0] c);
        return c inside {4'b0001, 4'b0010, 4'b0101, 4'b0110};
    endfunction

    // Operand capture; contents only matter once the port reaches PEND.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (state[p] == S_IDLE && req_cmd_in[4*p +: 4] != 4'h0) begin
                cmd_q[p] <= req_cmd_in[4*p +: 4];
                op1_q[p] <= req_data_in[DW*p +: DW];
            end
            if (state[p] == S_OP2) begin
                op2_q[p] <= req_data_in[DW*p +: DW];
            end
        end
    end

    // First PEND port at or after rr_ptr, wrapping modulo NPORTS.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_idx = TAGW'((int'(rr_ptr) + k) % NPORTS);
            if (!gnt_found && state[scan_idx] == S_PEND) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                state[p] <= S_IDLE;
            end
            rr_ptr            <= '0;
            out_resp          <= '0;
            out_data          <= '0;
            alu.alu_req_valid <= 1'b0;
            alu.alu_cmd       <= '0;
            alu.alu_op1       <= '0;
            alu.alu_op2       <= '0;
            alu.alu_req_tag   <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                case (state[p])
                    S_IDLE: begin
                        if (req_cmd_in[4*p +: 4] != 4'h0) state[p] <= S_OP2;
                    end
                    S_OP2: begin
                        if (is_alu_cmd(cmd_q[p])) begin
                            state[p] <= S_PEND;
                        end else begin
                            state[p]          <= S_IDLE;
                            out_resp[2*p +: 2] <= 2'b10;
                        end
                    end
                    S_PEND: begin
                        if (alu.alu_req_valid && alu.alu_req_ready && alu.alu_req_tag == TAGW'(p)) begin
                            state[p] <= S_ISSUED;
`ifdef CALC_SCHED_TIMEOUT_EN
                            wd_cnt[p] <= '0;
`endif
                        end
                    end
                    S_ISSUED: begin
                        if (alu.alu_resp_valid && alu.alu_resp_tag == TAGW'(p)) begin
                            state[p]            <= S_IDLE;
                            out_resp[2*p +: 2]  <= alu.alu_resp;
                            out_data[DW*p +: DW] <= alu.alu_result;
`ifdef CALC_SCHED_TIMEOUT_EN
                        end else if (wd_cnt[p] == CNT_W'(TIMEOUT - 1)) begin
                            state[p]           <= S_IDLE;
                            out_resp[2*p +: 2] <= 2'b11;
                        end else begin
                            wd_cnt[p] <= wd_cnt[p] + 1'b1;
`endif
                        end
                    end
                    default: state[p] <= S_IDLE;
                endcase
            end

            // A held request stays frozen until accepted; a new grant needs an idle channel.
            if (alu.alu_req_valid) begin
                if (alu.alu_req_ready) begin
                    alu.alu_req_valid <= 1'b0;
                    if (alu.alu_req_tag == TAGW'(NPORTS - 1)) rr_ptr <= '0;
                    else                                      rr_ptr <= alu.alu_req_tag + 1'b1;
                end
            end else if (gnt_found) begin
                alu.alu_req_valid <= 1'b1;
                alu.alu_cmd       <= cmd_q[gnt_idx];
                alu.alu_op1       <= op1_q[gnt_idx];
                alu.alu_op2       <= op2_q[gnt_idx];
                alu.alu_req_tag   <= gnt_idx;
            end
        end
    end
endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed self-checking bench for calc_port_scheduler with a fixed-latency ALU model.
// Timeout scenario runs only when CALC_SCHED_TIMEOUT_EN is defined.
module tb_calc_port_scheduler;
    logic         c_clk;
    logic         reset;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic [7:0]   out_resp;
    logic [127:0] out_data;

    logic        tb_ready, alu_silent, alu_manual;
    logic        man_v, model_v;
    logic [1:0]  man_resp, model_resp;
    logic [31:0] man_result, model_result;
    logic [1:0]  man_tag, model_tag;
    logic        acc_now, s0_v, s1_v;
    logic [1:0]  acc_tag, s0_tag, s1_tag;
    logic [31:0] acc_res, s0_res, s1_res;
    int          acc_log [$];

    int          checks, errors;
    int          got_cnt [4];
    logic [1:0]  got_resp [4];
    logic [31:0] got_data [4];

    calc_port_scheduler_if #(.DW(32), .TAGW(2)) alu_bus ();

    calc_port_scheduler #(.NPORTS(4), .DW(32), .TIMEOUT(16), .TAGW(2)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .alu         (alu_bus.master)
    );

    assign alu_bus.alu_req_ready  = tb_ready;
    assign alu_bus.alu_resp_valid = alu_manual ? man_v      : model_v;
    assign alu_bus.alu_resp       = alu_manual ? man_resp   : model_resp;
    assign alu_bus.alu_result     = alu_manual ? man_result : model_result;
    assign alu_bus.alu_resp_tag   = alu_manual ? man_tag    : model_tag;

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    function automatic logic [31:0] alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    // ALU model: accept seen at edge A, result presented for sampling at edge A+3.
    always @(posedge c_clk) begin
        acc_now <= 1'b0;
        if (reset && alu_bus.alu_req_valid && tb_ready) begin
            acc_now <= 1'b1;
            acc_tag <= alu_bus.alu_req_tag;
            acc_res <= alu_calc(alu_bus.alu_cmd, alu_bus.alu_op1, alu_bus.alu_op2);
            acc_log.push_back(int'(alu_bus.alu_req_tag));
        end
    end

    always @(negedge c_clk) begin
        model_v      <= s1_v;
        model_tag    <= s1_tag;
        model_result <= s1_res;
        model_resp   <= 2'b01;
        s1_v   <= s0_v;
        s1_tag <= s0_tag;
        s1_res <= s0_res;
        s0_v   <= acc_now && !alu_silent;
        s0_tag <= acc_tag;
        s0_res <= acc_res;
    end

    task automatic send(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        @(negedge c_clk);
        req_cmd_in[4*p +: 4]    = cmd;
        req_data_in[32*p +: 32] = a;
        @(negedge c_clk);
        req_cmd_in[4*p +: 4]    = 4'h0;
        req_data_in[32*p +: 32] = b;
    endtask

    task automatic collect(input int cycles);
        for (int p = 0; p < 4; p++) begin
            got_cnt[p] = 0; got_resp[p] = 2'b00; got_data[p] = 32'h0;
        end
        for (int i = 0; i < cycles; i++) begin
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                if (out_resp[2*p +: 2] != 2'b00) begin
                    got_cnt[p]++;
                    got_resp[p] = out_resp[2*p +: 2];
                    got_data[p] = out_data[32*p +: 32];
                end
            end
        end
    endtask

    task automatic do_reset;
        @(negedge c_clk);
        reset = 1'b0; req_cmd_in = '0;
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_cmd_in  = 16'h2111;
        req_data_in = {4{32'hA5A5_0001}};
        for (int i = 0; i < 3; i++) begin
            @(negedge c_clk);
            checks++;
            if (out_resp !== 8'h00) begin errors++; $display("FAIL reset_resp cyc%0d: got %h expected 00", i, out_resp); end
            checks++;
            if (alu_bus.alu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d: got %b expected 0", i, alu_bus.alu_req_valid); end
        end
        reset = 1'b1; req_cmd_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge c_clk);
            checks++;
            if (out_resp !== 8'h00 || out_data !== 128'h0) begin errors++; $display("FAIL post_reset_idle: got %h/%h expected 00/0", out_resp, out_data); end
            checks++;
            if (alu_bus.alu_req_valid !== 1'b0 || alu_bus.alu_req_tag !== 2'd0 || alu_bus.alu_cmd !== 4'h0) begin
                errors++; $display("FAIL post_reset_alu: got valid %b tag %0d cmd %h expected 0", alu_bus.alu_req_valid, alu_bus.alu_req_tag, alu_bus.alu_cmd);
            end
        end
    endtask

    task automatic test_single_add;
        int lat;
        lat = 0;
        send(0, 4'b0001, 32'h8000_2345, 32'h0001_0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge c_clk);
            lat++;
            if (out_resp[1:0] != 2'b00) break;
        end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL add_latency: got %0d expected 6", lat); end
        checks++;
        if (out_resp[1:0] !== 2'b01) begin errors++; $display("FAIL add_resp: got %b expected 01", out_resp[1:0]); end
        checks++;
        if (out_data[31:0] !== 32'h8001_2345) begin errors++; $display("FAIL add_data: got %h expected 80012345", out_data[31:0]); end
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'h00 || out_data[31:0] !== 32'h0) begin errors++; $display("FAIL add_one_cycle: got %h/%h expected 00/0", out_resp, out_data[31:0]); end
    endtask

    task automatic test_input_error;
        int base;
        logic saw_valid;
        base = acc_log.size();
        saw_valid = 1'b0;
        send(2, 4'b0011, 32'h0000_0005, 32'h0000_0007);
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'b0010_0000) begin errors++; $display("FAIL inerr_resp: got %b expected 00100000", out_resp); end
        checks++;
        if (out_data[95:64] !== 32'h0) begin errors++; $display("FAIL inerr_data: got %h expected 0", out_data[95:64]); end
        if (alu_bus.alu_req_valid) saw_valid = 1'b1;
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'h00) begin errors++; $display("FAIL inerr_one_cycle: got %b expected 0", out_resp); end
        for (int i = 0; i < 6; i++) begin
            @(negedge c_clk);
            if (alu_bus.alu_req_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || acc_log.size() != base) begin
            errors++; $display("FAIL inerr_alu_untouched: got valid %b accepts %0d expected 0/0", saw_valid, acc_log.size() - base);
        end
    endtask

    task automatic test_backpressure;
        int base;
        base = acc_log.size();
        tb_ready = 1'b0;
        send(3, 4'b0001, 32'h1234_5678, 32'h0000_0111);
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            if (alu_bus.alu_req_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge c_clk);
            checks++;
            if (alu_bus.alu_req_valid !== 1'b1 || alu_bus.alu_cmd !== 4'b0001 || alu_bus.alu_op1 !== 32'h1234_5678 ||
                alu_bus.alu_op2 !== 32'h0000_0111 || alu_bus.alu_req_tag !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got v%b c%h %h %h t%0d expected v1 c1 12345678 00000111 t3", i,
                         alu_bus.alu_req_valid, alu_bus.alu_cmd, alu_bus.alu_op1, alu_bus.alu_op2, alu_bus.alu_req_tag);
            end
        end
        tb_ready = 1'b1;
        @(negedge c_clk);
        checks++;
        if (alu_bus.alu_req_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", alu_bus.alu_req_valid); end
        checks++;
        if (acc_log.size() != base + 1 || acc_log[base] != 3) begin errors++; $display("FAIL bp_single_accept: got %0d accepts expected 1 of tag 3", acc_log.size() - base); end
        collect(8);
        checks++;
        if (got_cnt[3] !== 1 || got_resp[3] !== 2'b01 || got_data[3] !== 32'h1234_5789) begin
            errors++; $display("FAIL bp_result: got cnt %0d resp %b data %h expected 1/01/12345789", got_cnt[3], got_resp[3], got_data[3]);
        end
        checks++;
        if (acc_log.size() != base + 1) begin errors++; $display("FAIL bp_no_reissue: got %0d accepts expected 1", acc_log.size() - base); end
    endtask

    task automatic test_simultaneous;
        send(0, 4'b0001, 32'h0000_0010, 32'h0000_0020);
        for (int i = 2; i <= 7; i++) begin
            @(negedge c_clk);
            if (i == 5) begin req_cmd_in[7:4] = 4'b1111; req_data_in[63:32] = 32'hFFFF_0000; end
            if (i == 6) begin req_cmd_in[7:4] = 4'b0000; req_data_in[63:32] = 32'h0000_FFFF; end
        end
        checks++;
        if (out_resp[1:0] !== 2'b01 || out_data[31:0] !== 32'h0000_0030) begin
            errors++; $display("FAIL simul_port0: got %b/%h expected 01/00000030", out_resp[1:0], out_data[31:0]);
        end
        checks++;
        if (out_resp[3:2] !== 2'b10 || out_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL simul_port1: got %b/%h expected 10/00000000", out_resp[3:2], out_data[63:32]);
        end
    endtask

    task automatic test_round_robin;
        int base;
        int ord_a [4];
        int ord_b [4];
        logic [31:0] exp_sum [4];
        ord_a = '{0, 1, 2, 3};
        ord_b = '{2, 3, 0, 1};
        exp_sum = '{32'h101, 32'h202, 32'h303, 32'h404};
        for (int pass = 0; pass < 2; pass++) begin
            base = acc_log.size();
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin req_cmd_in[4*p +: 4] = 4'b0001; req_data_in[32*p +: 32] = 32'h100 * (p + 1); end
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin req_cmd_in[4*p +: 4] = 4'b0000; req_data_in[32*p +: 32] = p + 1; end
            collect(24);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (base + i >= acc_log.size() || acc_log[base + i] != (pass == 0 ? ord_a[i] : ord_b[i])) begin
                    errors++; $display("FAIL rr_order pass%0d slot%0d: got %0d expected %0d", pass, i,
                                       (base + i < acc_log.size()) ? acc_log[base + i] : -1, pass == 0 ? ord_a[i] : ord_b[i]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (got_cnt[p] !== 1 || got_resp[p] !== 2'b01 || got_data[p] !== exp_sum[p]) begin
                    errors++; $display("FAIL rr_result pass%0d port%0d: got cnt %0d resp %b data %h expected 1/01/%h", pass, p, got_cnt[p], got_resp[p], got_data[p], exp_sum[p]);
                end
            end
            if (pass == 0) begin
                send(1, 4'b0010, 32'h0000_0009, 32'h0000_0002);
                collect(10);
                checks++;
                if (got_cnt[1] !== 1 || got_data[1] !== 32'h0000_0007) begin
                    errors++; $display("FAIL rr_port1_alone: got cnt %0d data %h expected 1/00000007", got_cnt[1], got_data[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issued;
        int base;
        base = acc_log.size();
        alu_silent = 1'b1;
        send(0, 4'b0001, 32'h0000_0001, 32'h0000_0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            if (acc_log.size() > base) break;
        end
        checks++;
        if (acc_log.size() != base + 1) begin errors++; $display("FAIL rmid_accept: got %0d accepts expected 1", acc_log.size() - base); end
        reset = 1'b0;
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'h00 || out_data !== 128'h0 || alu_bus.alu_req_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs: got %h valid %b expected 00/0", out_resp, alu_bus.alu_req_valid);
        end
        reset = 1'b1;
        @(negedge c_clk);
        alu_manual = 1'b1; man_v = 1'b1; man_tag = 2'd0; man_resp = 2'b01; man_result = 32'hDEAD_BEEF;
        @(negedge c_clk);
        man_v = 1'b0; alu_manual = 1'b0;
        checks++;
        if (out_resp !== 8'h00 || out_data[31:0] !== 32'h0) begin errors++; $display("FAIL rmid_late_resp: got %h/%h expected 00/0", out_resp, out_data[31:0]); end
        alu_silent = 1'b0;
    endtask

`ifdef CALC_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int base;
        logic early;
        base = acc_log.size();
        early = 1'b0;
        alu_silent = 1'b1;
        send(1, 4'b0001, 32'h0000_0003, 32'h0000_0004);
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            if (acc_log.size() > base) break;
        end
        for (int k = 1; k < 16; k++) begin
            @(negedge c_clk);
            if (out_resp != 8'h00) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL to_early: got early response expected none before cycle 16"); end
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'b0000_1100 || out_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL to_fire: got %b/%h expected 00001100/0", out_resp, out_data[63:32]);
        end
        @(negedge c_clk);
        checks++;
        if (out_resp !== 8'h00) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", out_resp); end
        alu_manual = 1'b1; man_v = 1'b1; man_tag = 2'd1; man_resp = 2'b01; man_result = 32'h0000_0007;
        @(negedge c_clk);
        man_v = 1'b0; alu_manual = 1'b0;
        checks++;
        if (out_resp !== 8'h00) begin errors++; $display("FAIL to_late_dropped: got %b expected 0", out_resp); end
        alu_silent = 1'b0;
        send(1, 4'b0001, 32'h0000_0003, 32'h0000_0004);
        collect(10);
        checks++;
        if (got_cnt[1] !== 1 || got_resp[1] !== 2'b01 || got_data[1] !== 32'h0000_0007) begin
            errors++; $display("FAIL to_port_reusable: got cnt %0d resp %b data %h expected 1/01/00000007", got_cnt[1], got_resp[1], got_data[1]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        tb_ready = 1'b1; alu_silent = 1'b0; alu_manual = 1'b0;
        man_v = 1'b0; man_tag = 2'd0; man_resp = 2'b00; man_result = 32'h0;
        req_cmd_in = '0; req_data_in = '0;
        test_reset();
        test_single_add();
        test_input_error();
        test_backpressure();
        test_simultaneous();
        do_reset();
        test_round_robin();
        test_reset_mid_issued();
`ifdef CALC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
